// File: rtl/sram_bank_ctrl_param.sv
// Banked single-port SRAM controller: tiles spsram units in rows (depth) and columns (width),
// with row-select read pipeline, per-column write mask, optional output register and fill sequencer.

module spsram #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 4
) (
    input  logic               clk,
    input  logic               cen_n,
    input  logic               wen_n,
    input  logic               oen_n,
    input  logic [BW_ADDR-1:0] addr,
    input  logic [BW_DATA-1:0] d,
    output logic [BW_DATA-1:0] q
);
    logic [BW_DATA-1:0] mem [2**BW_ADDR];
    logic [BW_DATA-1:0] q_mem;
    logic [BW_DATA-1:0] q_out;

    // Array read latches into q_mem; q_out is the macro's output flop, so
    // data appears one edge after the read and holds until the next read.
    always_ff @(posedge clk) begin
        if (!cen_n) begin
            if (!wen_n) mem[addr] <= d;
            else        q_mem     <= mem[addr];
        end
        q_out <= q_mem;
    end

    assign q = oen_n ? '0 : q_out;
endmodule

module sram_bank_ctrl_param #(
    parameter int                      BW_DATA      = 64,
    parameter int                      BW_ADDR      = 8,
    parameter int                      BW_DATA_UNIT = 32,
    parameter int                      BW_ADDR_UNIT = 4,
    parameter int                      OUT_REG      = 1,
    parameter logic [BW_DATA_UNIT-1:0] INIT_VAL     = '0
) (
    input  logic                                   i_clk,
    input  logic                                   i_rstn,
    input  logic                                   i_req,
    input  logic                                   i_wr,
    input  logic [BW_ADDR-1:0]                     i_addr,
    input  logic [BW_DATA-1:0]                     i_data,
    input  logic [BW_DATA/BW_DATA_UNIT-1:0]        i_wmask,
    input  logic                                   i_clr,
    output logic                                   o_ready,
    output logic                                   o_init_done,
    output logic                                   o_rvalid,
    output logic [BW_DATA-1:0]                     o_rdata
);
    localparam int N_ROW  = 2**(BW_ADDR-BW_ADDR_UNIT);
    localparam int N_COL  = BW_DATA/BW_DATA_UNIT;
    localparam int BW_ROW = (BW_ADDR > BW_ADDR_UNIT) ? BW_ADDR-BW_ADDR_UNIT : 1;
    localparam int STAGES = 1 + ((OUT_REG != 0) ? 1 : 0);

    typedef enum logic {S_INIT, S_RUN} state_t;

    typedef struct packed {
        logic                    init;
        logic                    act;
        logic                    wr;
        logic [BW_ROW-1:0]       row;
        logic [BW_ADDR_UNIT-1:0] word;
    } tile_cmd_t;

    state_t                           state;
    logic [BW_ADDR-1:0]               cnt;
    logic                             acc;
    logic                             rd_acc;
    logic                             wr_acc;
    logic [BW_ADDR-1:0]               t_addr;
    tile_cmd_t                        cmd;
    logic [STAGES:0]                  vld_pipe;
    logic [BW_ROW-1:0]                sel_d1;
    logic [BW_ROW-1:0]                sel_d2;
    logic                             rd_seen;
    logic [BW_DATA-1:0]               rdata_q;
    logic [BW_DATA-1:0]               mux_data;
    logic [N_ROW-1:0][BW_DATA-1:0]    row_q;

    // o_ready is high exactly in RUN, so it doubles as the accept qualifier.
    assign acc    = o_ready && i_req && !i_clr;
    assign rd_acc = acc && !i_wr;
    assign wr_acc = acc && i_wr;

    assign cmd.init = (state == S_INIT) && i_rstn;
    assign cmd.act  = cmd.init || acc;
    assign cmd.wr   = cmd.init || wr_acc;
    assign t_addr   = cmd.init ? cnt : i_addr;
    assign cmd.row  = BW_ROW'(t_addr >> BW_ADDR_UNIT);
    assign cmd.word = t_addr[BW_ADDR_UNIT-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state       <= S_INIT;
            cnt         <= '0;
            o_ready     <= 1'b0;
            o_init_done <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state       <= S_RUN;
                        o_ready     <= 1'b1;
                        o_init_done <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_clr) begin
                        state   <= S_INIT;
                        cnt     <= '0;
                        o_ready <= 1'b0;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Row index follows the tile's two-edge read path so the mux always
    // points at the row whose output flop holds the newest read data.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            vld_pipe <= '0;
            sel_d1   <= '0;
            sel_d2   <= '0;
            rd_seen  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], rd_acc};
            if (rd_acc) sel_d1 <= cmd.row;
            if (vld_pipe[0]) begin
                sel_d2  <= sel_d1;
                rd_seen <= 1'b1;
            end
            if (vld_pipe[1]) rdata_q <= mux_data;
        end
    end

    assign mux_data = row_q[sel_d2];
    assign o_rvalid = vld_pipe[STAGES];
    assign o_rdata  = (OUT_REG != 0) ? rdata_q : (rd_seen ? mux_data : '0);

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        for (genvar c = 0; c < N_COL; c++) begin : g_col
            logic hit;
            logic [BW_DATA_UNIT-1:0] wdata;

            // Masked-off columns stay disabled so their contents are untouched.
            assign hit   = cmd.act && (cmd.row == BW_ROW'(r)) &&
                           (cmd.init || !cmd.wr || i_wmask[c]);
            assign wdata = cmd.init ? INIT_VAL : i_data[c*BW_DATA_UNIT +: BW_DATA_UNIT];

            spsram #(
                .BW_DATA (BW_DATA_UNIT),
                .BW_ADDR (BW_ADDR_UNIT)
            ) u_tile (
                .clk   (i_clk),
                .cen_n (!hit),
                .wen_n (!cmd.wr),
                .oen_n (sel_d2 != BW_ROW'(r)),
                .addr  (cmd.word),
                .d     (wdata),
                .q     (row_q[r][c*BW_DATA_UNIT +: BW_DATA_UNIT])
            );
        end
    end
endmodule
